// File: rtl/half_adder.sv
// half_adder: registered 1-bit half adder with valid handshake and synchronized reset release.
// Optional saturating carry-event counter is enabled by defining HALF_ADDER_CARRY_CNT_EN.
module half_adder #(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic carry,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic in_valid,
    output logic out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
        $error("half_adder: CNT_W must be in 2..32");
    end

    logic [1:0] r_rst_sync;
    logic       r_carry;
    logic       r_sum;
    logic       r_out_valid;
    logic       w_accept;

    // reset asserts immediately, releases only after two clean clk edges
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};

    assign w_accept = in_valid && r_rst_sync[1];

    // capture a+b on accepted cycles, otherwise hold; valid follows acceptance
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_carry     <= 1'b0;
            r_sum       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_carry <= a & b;
                r_sum   <= a ^ b;
            end
        end

    assign carry     = r_carry;
    assign sum       = r_sum;
    assign out_valid = r_out_valid;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] r_carry_cnt;

    // count accepted operations that produce a carry, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                                      r_carry_cnt <= '0;
        else if (w_accept && a && b && r_carry_cnt != '1) r_carry_cnt <= r_carry_cnt + CNT_W'(1);

    assign carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed and randomized self-checking bench for half_adder.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic carry;
    logic sum;
    logic a;
    logic b;
    logic in_valid;
    logic out_valid;
`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [1:0] carry_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic ec, es, ev;
    int ecnt;

    always #5 clk = ~clk;

    half_adder #(.CNT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .carry    (carry),
        .sum      (sum),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .out_valid(out_valid)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_cnt(carry_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input logic vv);
        a        = va;
        b        = vb;
        in_valid = vv;
    endtask

    task automatic check_out(input string tag, input logic xc, input logic xs, input logic xv);
        check({tag, ".carry"}, 32'(carry), 32'(xc));
        check({tag, ".sum"}, 32'(sum), 32'(xs));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(xv));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        step();
        step();
        check_out("reset", 1'b0, 1'b0, 1'b0);
`ifdef HALF_ADDER_CARRY_CNT_EN
        check("reset.cnt", 32'(carry_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        step();
        step();
        drive(1'b0, 1'b0, 1'b1);
        step();
        check_out("op00", 1'b0, 1'b0, 1'b1);
`ifdef HALF_ADDER_CARRY_CNT_EN
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            step();
            check("cnt_sat", 32'(carry_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        drive(1'b1, 1'b0, 1'b1);
        step();
        check("cnt_nocarry", 32'(carry_cnt), 32'd3);
`endif
        drive(1'b1, 1'b0, 1'b1);
        step();
        check_out("b2b_10", 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        step();
        check_out("b2b_01", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        step();
        check_out("b2b_11", 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        step();
        check_out("op01", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        step();
        check_out("hold1", 1'b0, 1'b1, 1'b0);
        step();
        check_out("hold2", 1'b0, 1'b1, 1'b0);
        drive(1'bx, 1'bx, 1'b0);
        step();
        check_out("hold_x", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        step();
        check_out("op11", 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 1'b0);
        step();
        check_out("rst_hold1", 1'b0, 1'b0, 1'b0);
        step();
        check_out("rst_hold2", 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        check_out("sync_edge1", 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_out("sync_edge3", 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        ec   = 1'b0;
        es   = 1'b0;
        ev   = 1'b0;
        ecnt = 0;
        for (int i = 0; i < 10000; i++) begin
            logic va, vb, vv;
            va = 1'($urandom);
            vb = 1'($urandom);
            vv = 1'($urandom);
            drive(va, vb, vv);
            ev = vv;
            if (vv) begin
                ec = va & vb;
                es = va ^ vb;
                if (va && vb && ecnt < 3) ecnt++;
            end
            step();
            check_out("rand", ec, es, ev);
`ifdef HALF_ADDER_CARRY_CNT_EN
            check("rand.cnt", 32'(carry_cnt), 32'(ecnt));
`endif
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
